// File: rtl/aes_word_loader.sv
// aes_word_loader: packs four 32-bit words (first word in [127:96]) into a registered 128-bit AES state; the round-0 key XOR is applied only when AES_LOADER_KEYXOR_EN is defined
module aes_word_loader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [31:0]  din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [127:0] key,
  output logic [127:0] do1,
  output logic         do_valid,
  input  logic         do_ready
);
  typedef enum logic {COLLECT, FULL} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [95:0] buf_q, buf_d;
  logic [127:0] do1_q, do1_d, key_m;
`ifdef AES_LOADER_KEYXOR_EN
  assign key_m = key;
`else
  logic unused_key;
  assign unused_key = ^key;
  assign key_m = '0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    do1_d = do1_q;
    if (clr) begin
      state_d = COLLECT;
      cnt_d = '0;
      buf_d = '0;
    end else if (state_q == COLLECT && din_valid) begin
      cnt_d = cnt_q + 2'd1;
      buf_d = {cnt_q == 2'd0 ? din : buf_q[95:64],
               cnt_q == 2'd1 ? din : buf_q[63:32],
               cnt_q == 2'd2 ? din : buf_q[31:0]};
      if (cnt_q == 2'd3) begin
        state_d = FULL;
        do1_d = {buf_q, din} ^ key_m;
        buf_d = '0;
      end
    end else if (state_q == FULL && do_ready) begin
      state_d = COLLECT;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q <= '0;
      buf_q <= '0;
      do1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      do1_q <= do1_d;
    end
  end
  assign din_ready = state_q == COLLECT;
  assign do_valid = state_q == FULL;
  assign do1 = do1_q;
endmodule

// File: tb/tb_aes_word_loader.sv
// tb_aes_word_loader: table-driven and scoreboard bench for aes_word_loader
`timescale 1ns/1ps
module tb_aes_word_loader;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, din_valid = 1'b0, do_ready = 1'b0;
  logic [31:0] din = '0;
  logic [127:0] key = '0;
  logic din_ready, do_valid;
  logic [127:0] do1;
  aes_word_loader dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .key(key), .do1(do1), .do_valid(do_valid), .do_ready(do_ready)
  );
  always #5 clk = ~clk;
`ifdef AES_LOADER_KEYXOR_EN
  localparam bit KX = 1'b1;
`else
  localparam bit KX = 1'b0;
`endif
  typedef struct {
    logic [127:0] blk;
    logic [127:0] k;
    int stall;
  } vec_t;
  vec_t tv[6];
  int n_vec = 0, n_err = 0;
  logic [127:0] sb[$];
  function automatic logic [127:0] expect_of(logic [127:0] b, logic [127:0] k);
    return KX ? (b ^ k) : b;
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pop_chk(string nm);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got output %h expected none (scoreboard empty)", nm, do1);
    end else chk(nm, do1, sb.pop_front());
  endtask
  task automatic send_words(logic [127:0] b, logic [127:0] k, int n);
    for (int i = 0; i < n; i++) begin
      chk("din_ready_collect", {127'b0, din_ready}, 128'd1);
      din = b[127-32*i -: 32];
      din_valid = 1'b1;
      key = (i == 3) ? k : rnd128();
      if (i == 3) sb.push_back(expect_of(b, k));
      tick();
    end
    din_valid = 1'b0;
    key = rnd128();
  endtask
  task automatic release_block();
    din_valid = 1'b0;
    do_ready = 1'b1;
    tick();
    do_ready = 1'b0;
    chk("release_valid", {127'b0, do_valid}, 128'd0);
    chk("release_ready", {127'b0, din_ready}, 128'd1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic [127:0] hold;
    logic [127:0] bb[2];
    logic [127:0] kk[2];
    int idx, got, c, first, second, ii;
    logic pv, acc;
    tv[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, 0};
    tv[1] = '{{128{1'b1}}, {128{1'b1}}, 3};
    tv[2] = '{128'h0, {32{4'ha}}, 10};
    tv[3] = '{128'h0123456789abcdeffedcba9876543210, 128'h0f0e0d0c0b0a09080706050403020100, 1};
    tv[4] = '{128'h80000000000000000000000000000001, 128'h0, 2};
    tv[5] = '{128'hdeadbeefcafef00d123456789abcdef0, 128'h55aa33cc0ff0f00f1234abcd5678ef01, 0};
    tick();
    tick();
    chk("reset_din_ready", {127'b0, din_ready}, 128'd1);
    chk("reset_do_valid", {127'b0, do_valid}, 128'd0);
    chk("reset_do1", do1, 128'h0);
    rst_n = 1'b1;
    for (int v = 0; v < 6; v++) begin
      send_words(tv[v].blk, tv[v].k, 4);
      chk("latency_do_valid", {127'b0, do_valid}, 128'd1);
      pop_chk("block_data");
      if (v == 0)
        chk("aes_kat", do1, KX ? 128'h193de3bea0f4e22b9ac68d2ae9f84808 : 128'h3243f6a8885a308d313198a2e0370734);
      hold = do1;
      for (int s = 0; s < tv[v].stall; s++) begin
        din_valid = 1'b1;
        din = $urandom;
        key = rnd128();
        tick();
        chk("stall_din_ready", {127'b0, din_ready}, 128'd0);
        chk("stall_do1", do1, hold);
      end
      release_block();
    end
    send_words(tv[3].blk, tv[3].k, 2);
    clr = 1'b1;
    din_valid = 1'b1;
    din = 32'hdeadbeef;
    tick();
    clr = 1'b0;
    din_valid = 1'b0;
    send_words(tv[0].blk, tv[0].k, 4);
    chk("clr_valid", {127'b0, do_valid}, 128'd1);
    pop_chk("clr_block");
    hold = do1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_full_valid", {127'b0, do_valid}, 128'd0);
    chk("clr_keeps_do1", do1, hold);
    send_words(tv[5].blk, tv[5].k, 4);
    pop_chk("pre_reset_block");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_full_valid", {127'b0, do_valid}, 128'd0);
    chk("rst_full_do1", do1, 128'h0);
    chk("rst_full_ready", {127'b0, din_ready}, 128'd1);
    send_words(tv[1].blk, tv[1].k, 3);
    rst_n = 1'b0;
    din_valid = 1'b1;
    din = $urandom;
    tick();
    rst_n = 1'b1;
    din_valid = 1'b0;
    send_words(tv[3].blk, tv[3].k, 4);
    chk("rst_mid_valid", {127'b0, do_valid}, 128'd1);
    pop_chk("rst_mid_block");
    release_block();
    bb[0] = tv[5].blk;
    bb[1] = tv[3].blk;
    kk[0] = tv[5].k;
    kk[1] = tv[0].k;
    idx = 0;
    got = 0;
    c = 0;
    first = -1;
    second = -1;
    pv = 1'b0;
    do_ready = 1'b1;
    while ((idx < 8 || got < 2) && c < 40) begin
      ii = idx < 8 ? idx : 7;
      din_valid = idx < 8;
      din = bb[ii>>2][127-32*(ii%4) -: 32];
      key = kk[ii>>2];
      acc = din_ready && din_valid;
      if (acc && ii % 4 == 3) sb.push_back(expect_of(bb[ii>>2], kk[ii>>2]));
      tick();
      c++;
      if (acc) idx++;
      if (do_valid) begin
        pop_chk("b2b_block");
        if (!pv) begin
          if (first < 0) first = c;
          else second = c;
        end
        got++;
      end
      pv = do_valid;
    end
    chk("b2b_blocks_seen", 128'(got), 128'd2);
    chk("b2b_gap", 128'(second - first), 128'd5);
    din_valid = 1'b0;
    tick();
    do_ready = 1'b0;
    chk("b2b_end_ready", {127'b0, din_ready}, 128'd1);
    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
